// File: rtl/memory_access.sv
// ---------------------------------------------------------------------------
// memory_access
//
// Memory stage of the five-stage Beta pipeline. Registers the execute-stage
// PC, IR, ALU result (Y) and store data (D). For LD/LDR/ST it drives a
// request/acknowledge data-memory port and stalls the upstream stages while
// the access is outstanding. It forwards PC, IR and result to write-back.
// While stalled, it substitutes a NOP bubble. On a misaligned address or a
// timed-out access, it substitutes the exception branch.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   pc, ir, y, d      PC, IR, ALU result / effective address, store data
//   op_ld_or_ldr      execute's IR is LD or LDR
//   op_st             execute's IR is ST
//   stall             upstream stages hold their registers this cycle
//   dmem_req/we       access request, 1 = write
//   dmem_addr/wdata   word address and store data
//   dmem_rdata/ack    read data, access complete this cycle
//   pc_next, ir_next,
//   y_next            PC, IR and result handed to write-back
// ---------------------------------------------------------------------------
module memory_access #(
  parameter int unsigned TIMEOUT         = 16,
  parameter logic [31:0] INST_NOP        = 32'h83FF_F800,  // ADD(R31,R31,R31)
  parameter logic [31:0] INST_BNE_EXCEPT = 32'h7BDF_0000   // BNE(R31,0,XP)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic [31:0] ir,
  input  logic [31:0] y,
  input  logic [31:0] d,
  input  logic        op_ld_or_ldr,
  input  logic        op_st,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic [31:0] pc_next,
  output logic [31:0] ir_next,
  output logic [31:0] y_next
);

  localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] wait_cnt;
  logic [15:0] wait_cnt_nxt;

  logic [31:0] pc_mem;
  logic [31:0] ir_mem;
  logic [31:0] y_mem;
  logic [31:0] d_mem;
  logic        ld_mem;
  logic        st_mem;

  logic        mem_op;
  logic        misaligned;
  logic        abort;
  logic        complete;

  assign mem_op     = ld_mem | st_mem;
  assign misaligned = mem_op & (y_mem[1:0] != 2'b00);

  assign dmem_we    = st_mem;
  assign dmem_wdata = d_mem;
  assign dmem_addr  = {y_mem[31:2], 2'b00};

  // An abort cycle lets the stage advance even though no ack arrived.
  assign stall = dmem_req & ~dmem_ack & ~abort;

  // Stage registers, FSM state and wait counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_mem   <= 32'h0000_0000;
      ir_mem   <= INST_NOP;
      y_mem    <= 32'h0000_0000;
      d_mem    <= 32'h0000_0000;
      ld_mem   <= 1'b0;
      st_mem   <= 1'b0;
      state    <= ST_RUN;
      wait_cnt <= 16'd0;
    end else begin
      if (!stall) begin
        pc_mem <= pc;
        ir_mem <= ir;
        y_mem  <= y;
        d_mem  <= d;
        ld_mem <= op_ld_or_ldr;
        st_mem <= op_st;
      end
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Access sequencing: request, completion and timeout abort.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    dmem_req     = 1'b0;
    complete     = 1'b0;
    abort        = 1'b0;
    case (state)
      ST_RUN: begin
        if (mem_op && !misaligned) begin
          dmem_req = 1'b1;
          if (dmem_ack) begin
            complete = 1'b1;
          end else begin
            state_nxt    = ST_WAIT;
            wait_cnt_nxt = 16'd1;
          end
        end else begin
          dmem_req = 1'b0;
        end
      end
      ST_WAIT: begin
        dmem_req = 1'b1;
        // An ack in the timeout cycle takes priority over the abort.
        if (dmem_ack) begin
          complete     = 1'b1;
          state_nxt    = ST_RUN;
          wait_cnt_nxt = 16'd0;
        end else if (wait_cnt == TIMEOUT_CNT) begin
          abort        = 1'b1;
          state_nxt    = ST_RUN;
          wait_cnt_nxt = 16'd0;
        end else begin
          wait_cnt_nxt = wait_cnt + 16'd1;
        end
      end
      default: begin
        state_nxt    = ST_RUN;
        wait_cnt_nxt = 16'd0;
      end
    endcase
  end

  // Write-back selection: exception, then bubble, then load data, then Y.
  always_comb begin
    pc_next = pc_mem;
    ir_next = ir_mem;
    y_next  = y_mem;
    if (misaligned || abort) begin
      ir_next = INST_BNE_EXCEPT;
      y_next  = 32'h0000_0000;
    end else if (stall) begin
      ir_next = INST_NOP;
      y_next  = 32'h0000_0000;
    end else if (ld_mem && complete) begin
      y_next = dmem_rdata;
    end else begin
      y_next = y_mem;
    end
  end

endmodule

// File: tb/tb_memory_access.sv
module tb_memory_access;

  localparam int unsigned TO      = 4;
  localparam logic [31:0] NOP     = 32'h83FF_F800;
  localparam logic [31:0] EXC     = 32'h7BDF_0000;
  localparam logic [31:0] ADD_IR  = 32'h8022_0800;
  localparam logic [31:0] LD_IR   = 32'h6022_0100;
  localparam logic [31:0] ST_IR   = 32'h6443_0200;
  localparam logic [31:0] IDLE_PC = 32'h0000_0F00;
  localparam logic [31:0] IDLE_Y  = 32'h0000_0077;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc, ir, y, d;
  logic        op_ld_or_ldr, op_st;
  logic        stall, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ack;
  logic [31:0] pc_next, ir_next, y_next;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] y;
    logic [31:0] d;
    logic        ld;
    logic        st;
    logic [7:0]  delay;  // ack delay in cycles; > TO means never acked
  } instr_t;

  memory_access #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .pc(pc), .ir(ir), .y(y), .d(d),
    .op_ld_or_ldr(op_ld_or_ldr), .op_st(op_st), .stall(stall),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .pc_next(pc_next), .ir_next(ir_next), .y_next(y_next)
  );

  always #5 clk = ~clk;

  task automatic set_in(input logic [31:0] p, input logic [31:0] i, input logic [31:0] yy,
                        input logic [31:0] dd, input logic l, input logic s);
    pc = p; ir = i; y = yy; d = dd; op_ld_or_ldr = l; op_st = s;
  endtask

  task automatic set_idle();
    set_in(IDLE_PC, ADD_IR, IDLE_Y, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; dmem_ack = 1'b0; dmem_rdata = 32'h0;
    set_idle();
    step(); step();
    rst = 1'b0;
    sample();
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %0h exp 0", dmem_req); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %0h exp 0", stall); end
    checks++; if (ir_next !== NOP) begin errors++; $display("FAIL reset_ir got %h exp %h", ir_next, NOP); end
    checks++; if (pc_next !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp 0", pc_next); end
    checks++; if (y_next !== 32'h0) begin errors++; $display("FAIL reset_y got %h exp 0", y_next); end
  endtask

  task automatic test_add();
    set_in(32'h40, ADD_IR, 32'h5, 32'h0, 1'b0, 1'b0);
    step(); set_idle(); sample();
    checks++; if (ir_next !== ADD_IR) begin errors++; $display("FAIL add_ir got %h exp %h", ir_next, ADD_IR); end
    checks++; if (y_next !== 32'h5) begin errors++; $display("FAIL add_y got %h exp 5", y_next); end
    checks++; if (pc_next !== 32'h40) begin errors++; $display("FAIL add_pc got %h exp 40", pc_next); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL add_stall got %0h exp 0", stall); end
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL add_req got %0h exp 0", dmem_req); end
  endtask

  task automatic test_ld_zero_wait();
    set_in(32'h44, LD_IR, 32'h100, 32'h0, 1'b1, 1'b0);
    step(); set_idle();
    dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    sample();
    checks++; if (y_next !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ld0_y got %h exp deadbeef", y_next); end
    checks++; if (ir_next !== LD_IR) begin errors++; $display("FAIL ld0_ir got %h exp %h", ir_next, LD_IR); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL ld0_stall got %0h exp 0", stall); end
    checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL ld0_req got %0h exp 1", dmem_req); end
    checks++; if (dmem_we !== 1'b0) begin errors++; $display("FAIL ld0_we got %0h exp 0", dmem_we); end
    checks++; if (dmem_addr !== 32'h100) begin errors++; $display("FAIL ld0_addr got %h exp 100", dmem_addr); end
    step(); dmem_ack = 1'b0;
  endtask

  task automatic test_st_wait3();
    set_in(32'h48, ST_IR, 32'h200, 32'h1234, 1'b0, 1'b1);
    step();
    set_in(32'h4C, ADD_IR, 32'h7, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      sample();
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL st3_stall[%0d] got %0h exp 1", i, stall); end
      checks++; if (ir_next !== NOP) begin errors++; $display("FAIL st3_bubble[%0d] got %h exp %h", i, ir_next, NOP); end
      checks++; if (y_next !== 32'h0) begin errors++; $display("FAIL st3_y[%0d] got %h exp 0", i, y_next); end
      checks++; if (dmem_we !== 1'b1) begin errors++; $display("FAIL st3_we[%0d] got %0h exp 1", i, dmem_we); end
      checks++; if (dmem_wdata !== 32'h1234) begin errors++; $display("FAIL st3_wdata[%0d] got %h exp 1234", i, dmem_wdata); end
      checks++; if (dmem_addr !== 32'h200) begin errors++; $display("FAIL st3_addr[%0d] got %h exp 200", i, dmem_addr); end
      step();
    end
    dmem_ack = 1'b1;
    sample();
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL st3_done_stall got %0h exp 0", stall); end
    checks++; if (ir_next !== ST_IR) begin errors++; $display("FAIL st3_done_ir got %h exp %h", ir_next, ST_IR); end
    checks++; if (y_next !== 32'h200) begin errors++; $display("FAIL st3_done_y got %h exp 200", y_next); end
    step(); dmem_ack = 1'b0; set_idle();
    sample();
    checks++; if (ir_next !== ADD_IR) begin errors++; $display("FAIL st3_resume_ir got %h exp %h", ir_next, ADD_IR); end
    checks++; if (y_next !== 32'h7) begin errors++; $display("FAIL st3_resume_y got %h exp 7", y_next); end
    checks++; if (pc_next !== 32'h4C) begin errors++; $display("FAIL st3_resume_pc got %h exp 4c", pc_next); end
  endtask

  task automatic test_misaligned();
    set_in(32'h50, LD_IR, 32'h102, 32'h0, 1'b1, 1'b0);
    step(); set_idle(); sample();
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL mis_req got %0h exp 0", dmem_req); end
    checks++; if (ir_next !== EXC) begin errors++; $display("FAIL mis_ir got %h exp %h", ir_next, EXC); end
    checks++; if (y_next !== 32'h0) begin errors++; $display("FAIL mis_y got %h exp 0", y_next); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mis_stall got %0h exp 0", stall); end
    checks++; if (pc_next !== 32'h50) begin errors++; $display("FAIL mis_pc got %h exp 50", pc_next); end
  endtask

  task automatic test_timeout(input logic ack_last);
    set_in(32'h54, LD_IR, 32'h300, 32'h0, 1'b1, 1'b0);
    step(); set_idle();
    for (int i = 0; i < int'(TO); i++) begin
      sample();
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL to_stall[%0d] got %0h exp 1", i, stall); end
      checks++; if (ir_next !== NOP) begin errors++; $display("FAIL to_bubble[%0d] got %h exp %h", i, ir_next, NOP); end
      step();
    end
    dmem_ack = ack_last; dmem_rdata = 32'hCAFE_F00D;
    sample();
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL to_end_stall ack=%0b got %0h exp 0", ack_last, stall); end
    if (ack_last) begin
      checks++; if (ir_next !== LD_IR) begin errors++; $display("FAIL to_ack_ir got %h exp %h", ir_next, LD_IR); end
      checks++; if (y_next !== 32'hCAFE_F00D) begin errors++; $display("FAIL to_ack_y got %h exp cafef00d", y_next); end
    end else begin
      checks++; if (ir_next !== EXC) begin errors++; $display("FAIL to_abort_ir got %h exp %h", ir_next, EXC); end
      checks++; if (y_next !== 32'h0) begin errors++; $display("FAIL to_abort_y got %h exp 0", y_next); end
    end
    checks++; if (pc_next !== 32'h54) begin errors++; $display("FAIL to_pc got %h exp 54", pc_next); end
    step(); dmem_ack = 1'b0; sample();
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL to_after_req got %0h exp 0", dmem_req); end
    checks++; if (ir_next !== ADD_IR) begin errors++; $display("FAIL to_after_ir got %h exp %h", ir_next, ADD_IR); end
  endtask

  task automatic test_reset_mid_wait();
    set_in(32'h60, LD_IR, 32'h400, 32'h0, 1'b1, 1'b0);
    step(); set_idle();
    step(); step();
    sample();
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rmw_wait_stall got %0h exp 1", stall); end
    rst = 1'b1;
    step(); rst = 1'b0;
    sample();
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL rmw_req got %0h exp 0", dmem_req); end
    checks++; if (ir_next !== NOP) begin errors++; $display("FAIL rmw_ir got %h exp %h", ir_next, NOP); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rmw_stall got %0h exp 0", stall); end
    set_in(32'h64, LD_IR, 32'h104, 32'h0, 1'b1, 1'b0);
    step(); set_idle();
    dmem_ack = 1'b1; dmem_rdata = 32'h1357_9BDF;
    sample();
    checks++; if (y_next !== 32'h1357_9BDF) begin errors++; $display("FAIL rmw_ld_y got %h exp 13579bdf", y_next); end
    checks++; if (ir_next !== LD_IR) begin errors++; $display("FAIL rmw_ld_ir got %h exp %h", ir_next, LD_IR); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rmw_ld_stall got %0h exp 0", stall); end
    step(); dmem_ack = 1'b0;
  endtask

  task automatic test_back_to_back();
    set_in(32'h70, LD_IR, 32'h500, 32'h0, 1'b1, 1'b0);
    step();
    set_in(32'h74, LD_IR, 32'h504, 32'h0, 1'b1, 1'b0);
    sample();
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL b2b_first_stall got %0h exp 1", stall); end
    step(); dmem_ack = 1'b1; dmem_rdata = 32'hAAAA_0001;
    sample();
    checks++; if (y_next !== 32'hAAAA_0001) begin errors++; $display("FAIL b2b_first_y got %h exp aaaa0001", y_next); end
    step(); dmem_ack = 1'b0; set_idle();
    sample();
    checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL b2b_second_req got %0h exp 1", dmem_req); end
    checks++; if (dmem_addr !== 32'h504) begin errors++; $display("FAIL b2b_second_addr got %h exp 504", dmem_addr); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL b2b_second_stall got %0h exp 1", stall); end
    step(); dmem_ack = 1'b1; dmem_rdata = 32'hBBBB_0002;
    sample();
    checks++; if (y_next !== 32'hBBBB_0002) begin errors++; $display("FAIL b2b_second_y got %h exp bbbb0002", y_next); end
    checks++; if (pc_next !== 32'h74) begin errors++; $display("FAIL b2b_second_pc got %h exp 74", pc_next); end
    step(); dmem_ack = 1'b0;
  endtask

  function automatic instr_t gen_instr(input int n);
    instr_t t;
    int kind;
    kind    = $urandom_range(0, 9);
    t.pc    = 32'h1000 + 32'(n) * 32'd4;
    t.ir    = $urandom;
    t.d     = $urandom;
    t.y     = $urandom & 32'hFFFF_FFFC;
    t.ld    = (kind == 4 || kind == 5 || kind == 8);
    t.st    = (kind == 6 || kind == 7 || kind == 9);
    if (kind >= 8) t.y = t.y | 32'($urandom_range(1, 3));
    t.delay = 8'($urandom_range(0, TO + 1));
    return t;
  endfunction

  // Transaction-level model: each instruction occupies the stage for a number
  // of cycles given by its ack delay, bounded by the timeout.
  task automatic test_random();
    instr_t cur, nxt;
    int k, done;
    logic is_mem, mis, e_stall, e_req, e_adv;
    logic [31:0] rd, e_ir, e_y;
    cur = gen_instr(0); set_in(cur.pc, cur.ir, cur.y, cur.d, cur.ld, cur.st);
    step();
    nxt = gen_instr(1); set_in(nxt.pc, nxt.ir, nxt.y, nxt.d, nxt.ld, nxt.st);
    k = 0; done = 0;
    for (int cyc = 0; cyc < 3000 && done < 150; cyc++) begin
      is_mem = cur.ld | cur.st;
      mis    = is_mem && (cur.y[1:0] != 2'b00);
      rd     = $urandom;
      dmem_rdata = rd;
      if (!is_mem || mis) dmem_ack = 1'($urandom_range(0, 1));
      else dmem_ack = (k == int'(cur.delay));
      if (!is_mem) begin
        e_req = 1'b0; e_stall = 1'b0; e_ir = cur.ir; e_y = cur.y; e_adv = 1'b1;
      end else if (mis) begin
        e_req = 1'b0; e_stall = 1'b0; e_ir = EXC; e_y = 32'h0; e_adv = 1'b1;
      end else if (k == int'(cur.delay)) begin
        e_req = 1'b1; e_stall = 1'b0; e_ir = cur.ir; e_y = cur.ld ? rd : cur.y; e_adv = 1'b1;
      end else if (k == int'(TO)) begin
        e_req = 1'b1; e_stall = 1'b0; e_ir = EXC; e_y = 32'h0; e_adv = 1'b1;
      end else begin
        e_req = 1'b1; e_stall = 1'b1; e_ir = NOP; e_y = 32'h0; e_adv = 1'b0;
      end
      sample();
      checks++; if (stall !== e_stall) begin errors++; $display("FAIL rnd_stall pc=%h k=%0d got %0h exp %0h", cur.pc, k, stall, e_stall); end
      checks++; if (dmem_req !== e_req) begin errors++; $display("FAIL rnd_req pc=%h k=%0d got %0h exp %0h", cur.pc, k, dmem_req, e_req); end
      checks++; if (ir_next !== e_ir) begin errors++; $display("FAIL rnd_ir pc=%h k=%0d got %h exp %h", cur.pc, k, ir_next, e_ir); end
      checks++; if (y_next !== e_y) begin errors++; $display("FAIL rnd_y pc=%h k=%0d got %h exp %h", cur.pc, k, y_next, e_y); end
      checks++; if (pc_next !== cur.pc) begin errors++; $display("FAIL rnd_pc k=%0d got %h exp %h", k, pc_next, cur.pc); end
      checks++; if (dmem_addr !== {cur.y[31:2], 2'b00}) begin errors++; $display("FAIL rnd_addr pc=%h got %h exp %h", cur.pc, dmem_addr, {cur.y[31:2], 2'b00}); end
      checks++; if (dmem_we !== cur.st) begin errors++; $display("FAIL rnd_we pc=%h got %0h exp %0h", cur.pc, dmem_we, cur.st); end
      checks++; if (dmem_wdata !== cur.d) begin errors++; $display("FAIL rnd_wdata pc=%h got %h exp %h", cur.pc, dmem_wdata, cur.d); end
      step();
      if (e_adv) begin
        cur = nxt;
        nxt = gen_instr(done + 2);
        set_in(nxt.pc, nxt.ir, nxt.y, nxt.d, nxt.ld, nxt.st);
        k = 0;
        done++;
      end else begin
        k++;
      end
    end
    dmem_ack = 1'b0;
    checks++; if (done < 150) begin errors++; $display("FAIL rnd_progress got %0d exp 150", done); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_ld_zero_wait();
    test_st_wait3();
    test_misaligned();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_reset_mid_wait();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_access.md
# memory_access

Memory stage of the five-stage Beta pipeline, directly downstream of the execute stage. Registers execute's PC, IR, ALU result (Y) and store data (D), drives a request/acknowledge data-memory port for LD/LDR/ST, and holds the upstream pipeline stalled while a memory access is outstanding. It forwards PC, IR and result to write-back, substituting a NOP bubble while stalled and the exception branch on misalignment or timeout.

## Interface
- `TIMEOUT`, 16: wait cycles without `dmem_ack` before an access is aborted; range 2..65535.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `pc`  in  32  PC from execute.
- `ir`  in  32  IR from execute.
- `y`  in  32  ALU result from execute (effective address for LD/LDR/ST).
- `d`  in  32  store data from execute.
- `op_ld_or_ldr`  in  1  execute's IR is LD or LDR.
- `op_st`  in  1  execute's IR is ST.
- `stall`  out  1  upstream stages hold their registers this cycle.
- `dmem_req`  out  1  access request.
- `dmem_we`  out  1  1 = write (ST), 0 = read.
- `dmem_addr`  out  32  word address, `{y_mem[31:2], 2'b00}`.
- `dmem_wdata`  out  32  store data.
- `dmem_rdata`  in  32  read data, valid when `dmem_ack` is high.
- `dmem_ack`  in  1  access complete this cycle.
- `pc_next`  out  32  PC to write-back.
- `ir_next`  out  32  IR to write-back.
- `y_next`  out  32  result to write-back (load data or pass-through Y).

## Operation
- Stage registers `pc_mem, ir_mem, y_mem, d_mem, ld_mem, st_mem` load from inputs on every edge where `stall` is 0; they hold when `stall` is 1.
- `mem_op = ld_mem | st_mem`; `misaligned = mem_op & (y_mem[1:0] != 0)`.
- FSM states: RUN, WAIT.
  - RUN, `mem_op` and not misaligned: `dmem_req`=1. If `dmem_ack`, the access completes and the state stays RUN. Otherwise go to WAIT, wait counter := 1.
  - WAIT: `dmem_req`=1. On `dmem_ack`, the access completes and the state goes to RUN, counter := 0. With no ack and counter = `TIMEOUT`, the access aborts and the state goes to RUN. Otherwise counter increments (16-bit).
- `dmem_we = st_mem`; `dmem_wdata = d_mem`; `dmem_addr` is always driven from `y_mem`. `dmem_ack` is ignored while `dmem_req`=0.
- Misaligned access: no request is issued and there is no stall. Outputs `ir_next` = `INST_BNE_EXCEPT`, `y_next` = 0.
- `stall = dmem_req & ~dmem_ack & ~abort`.
- Output selection, in priority order:
  - Misaligned or abort: `ir_next` = `INST_BNE_EXCEPT`, `y_next` = 0.
  - `stall`: `ir_next` = `INST_NOP`, `y_next` = 0 (bubble).
  - Completing load: `y_next = dmem_rdata`.
  - Otherwise: `y_next = y_mem`.
  - In every case `pc_next = pc_mem`, and otherwise `ir_next = ir_mem`.
- Non-memory instructions pass through in one cycle and never stall.

## Timing
- Reset (synchronous): `ir_mem` = `INST_NOP`; `pc_mem, y_mem, d_mem` = 0; `ld_mem, st_mem` = 0; state RUN; counter 0.
- After reset: `dmem_req`=0, `stall`=0, `ir_next`=`INST_NOP`, `pc_next`=0, `y_next`=0.
- Latency is 1 cycle register-to-output for non-memory and zero-wait accesses. For an access acked N cycles after the request cycle, the stage stalls N cycles and emits N bubbles before the real instruction.
- `stall`, `dmem_req` and all `*_next` outputs are combinational from stage registers, FSM state and `dmem_ack`. `dmem_ack` must not depend combinationally on `stall`.
- Abort fires in the cycle the counter equals `TIMEOUT`. `stall` is 0 that cycle and the stage advances on that edge. An ack arriving in the same cycle wins over abort.
- Reset asserted mid-WAIT: `dmem_req` drops the cycle after the reset edge, the FSM returns to RUN, and the outstanding access is abandoned. The memory must tolerate an abandoned request.
- Back-to-back memory ops: the next op's request is asserted in the cycle after the previous op completes. There are no dead cycles.

## Test plan
- Reset, then ADD with `y`=0x0000_0005 → next cycle `ir_next`=ADD, `y_next`=5, `stall`=0, `dmem_req`=0.
- LD, `y`=0x100, ack in the same cycle, `dmem_rdata`=0xDEAD_BEEF → `y_next`=0xDEAD_BEEF, no stall, `dmem_we`=0, `dmem_addr`=0x100.
- ST, `y`=0x200, `d`=0x1234, ack 3 cycles late → `stall`=1 for 3 cycles with `ir_next`=NOP, `dmem_we`=1, `dmem_wdata`=0x1234 held. Then ST emitted and upstream inputs resume.
- LD, `y`=0x102 (misaligned) → `dmem_req` never asserted, `ir_next`=`INST_BNE_EXCEPT`, `y_next`=0, no stall.
- LD with `TIMEOUT`=4, no ack → 4 stall cycles, then `ir_next`=`INST_BNE_EXCEPT`, FSM RUN. Repeat with ack exactly at counter=4 → load completes normally.
- `rst` in the second WAIT cycle of a load → next cycle `dmem_req`=0, `ir_next`=NOP, `stall`=0. A following LD/ack sequence works normally.
